dcache_mem_bridge: RTL and testbench

- Sits directly downstream of the data cache, between its miss/write-through port and the main-memory bus.
- Buffers write-through stores in a small FIFO write buffer and drains them to memory in the background.
- Services read misses with priority over draining, and forwards read data from the write buffer when the address matches a buffered store.
- Converts the cache's single-cycle request pulses into a req/ack handshake on the memory bus.

---
 rtl/dcache_mem_bridge_if.sv | 35 +++
 rtl/dcache_mem_bridge.sv | 138 +++++++++++++
 tb/tb_dcache_mem_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_bridge_if.sv
// rtl/dcache_mem_bridge_if.sv - cache-side request/response and memory-bus signal bundle
interface dcache_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              req_err;
    logic [CNT_W-1:0]  wb_count;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    // Environment view: the cache plus the memory model.
    modport master (
        output req_rd, req_wr, req_addr, req_wdata, bus_ack, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, req_err, wb_count,
               bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, bus_ack, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, req_err, wb_count,
               bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/dcache_mem_bridge.sv
// rtl/dcache_mem_bridge.sv - write-buffered, read-forwarding bridge from data cache to memory bus
module dcache_mem_bridge #(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input logic              clk,
    input logic              rst,
    dcache_mem_bridge_if.slave io
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, RD_RSP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-3:0] wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] wb_data [WB_DEPTH];
    logic [PTR_W-1:0]  head, tail, idx;
    logic [CNT_W-1:0]  count;
    logic              rd_pending;
    logic [ADDR_W-3:0] rd_addr;
    logic              full, ready, one_req, acc_wr, acc_rd, pop, rd_done;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              bus_req, bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              rsp_valid, req_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^io.req_addr[1:0];

    assign full    = (count == CNT_W'(WB_DEPTH));
    assign ready   = !rst && !full && (state == IDLE || state == WR_BUS) && !rd_pending;
    assign one_req = io.req_rd ^ io.req_wr;
    assign acc_wr  = ready && one_req && io.req_wr;
    assign acc_rd  = ready && one_req && io.req_rd;
    assign pop     = (state == WR_BUS) && io.bus_ack;
    assign rd_done = (state == RD_BUS) && io.bus_ack;

    // Walk oldest to newest so the last match wins, giving the youngest store's data.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (i < int'(count) && wb_addr[idx] == io.req_addr[ADDR_W-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                if (rd_pending)      state_nxt = RD_BUS;
                else if (count != 0) state_nxt = WR_BUS;
            end
            WR_BUS: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = {wb_addr[head], 2'b00};
                bus_wdata = wb_data[head];
                if (io.bus_ack) state_nxt = IDLE;
            end
            RD_BUS: begin
                bus_req  = 1'b1;
                bus_addr = {rd_addr, 2'b00};
                if (io.bus_ack) state_nxt = RD_RSP;
            end
            RD_RSP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            wb_addr[tail] <= io.req_addr[ADDR_W-1:2];
            wb_data[tail] <= io.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rd_pending <= 1'b0;
            rd_addr    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            req_err    <= 1'b0;
        end else begin
            req_err   <= io.req_rd && io.req_wr;
            rsp_valid <= (acc_rd && fwd_hit) || rd_done;
            if (acc_rd && fwd_hit) rsp_rdata <= fwd_data;
            else if (rd_done)      rsp_rdata <= io.bus_rdata;
            if (acc_wr) tail <= tail + 1'b1;
            if (pop)    head <= head + 1'b1;
            case ({acc_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (acc_rd && !fwd_hit) begin
                rd_pending <= 1'b1;
                rd_addr    <= io.req_addr[ADDR_W-1:2];
            end else if (rd_done) begin
                rd_pending <= 1'b0;
            end
        end
    end

    assign io.req_ready = ready;
    assign io.rsp_valid = rsp_valid;
    assign io.rsp_rdata = rsp_rdata;
    assign io.req_err   = req_err;
    assign io.wb_count  = count;
    assign io.bus_req   = bus_req;
    assign io.bus_we    = bus_we;
    assign io.bus_addr  = bus_addr;
    assign io.bus_wdata = bus_wdata;
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// tb/tb_dcache_mem_bridge.sv - directed self-checking bench for dcache_mem_bridge
module tb_dcache_mem_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic        mem_auto = 1'b1;
    int          mem_wait = 0;
    int          wait_cnt = 0;
    logic        auto_ack = 1'b0;
    logic        manual_ack = 1'b0;
    int          n_log = 0;
    logic        log_we   [0:31];
    logic [31:0] log_addr [0:31];
    logic [31:0] log_data [0:31];
    int          base;

    dcache_mem_bridge_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bif ();

    dcache_mem_bridge #(.WB_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bif)
    );

    always #5 clk = ~clk;

    assign bif.bus_ack = auto_ack | manual_ack;

    // Memory model: acks after mem_wait extra cycles and logs every completed transaction.
    always @(negedge clk) begin
        if (mem_auto && bif.bus_req) begin
            if (wait_cnt >= mem_wait) begin
                auto_ack = 1'b1;
                wait_cnt = 0;
                if (n_log < 32) begin
                    log_we[n_log]   = bif.bus_we;
                    log_addr[n_log] = bif.bus_addr;
                    log_data[n_log] = bif.bus_wdata;
                end
                n_log++;
            end else begin
                auto_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            auto_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bif.req_rd    = rd;
        bif.req_wr    = wr;
        bif.req_addr  = a;
        bif.req_wdata = d;
    endtask

    task automatic wait_log(input int target);
        for (int i = 0; i < 200 && n_log < target; i++) tick();
        check("log_count", 64'(n_log), 64'(target));
    endtask

    task automatic check_log(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        check("log_we", 64'(log_we[i]), 64'(we));
        check("log_addr", 64'(log_addr[i]), 64'(a));
        if (we) check("log_data", 64'(log_data[i]), 64'(d));
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bif.bus_rdata = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_ready", 64'(bif.req_ready), 64'd0);
        check("rst_bus_req", 64'(bif.bus_req), 64'd0);
        check("rst_wb_count", 64'(bif.wb_count), 64'd0);
        check("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        check("rst_req_err", 64'(bif.req_err), 64'd0);
        rst = 1'b0;
        tick();

        // 1: read miss, zero-wait memory
        mem_wait = 0;
        bif.bus_rdata = 32'hDEADBEEF;
        base = n_log;
        check("t1_ready", 64'(bif.req_ready), 64'd1);
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("t1_req_t1", 64'(bif.bus_req), 64'd0);
        tick();
        check("t1_req_t2", 64'(bif.bus_req), 64'd1);
        check("t1_we_t2", 64'(bif.bus_we), 64'd0);
        check("t1_addr_t2", 64'(bif.bus_addr), 64'h100);
        tick();
        check("t1_rsp_valid", 64'(bif.rsp_valid), 64'd1);
        check("t1_rsp_rdata", 64'(bif.rsp_rdata), 64'hDEADBEEF);
        check("t1_req_drop", 64'(bif.bus_req), 64'd0);
        tick();
        check("t1_rsp_pulse", 64'(bif.rsp_valid), 64'd0);
        check("t1_wb_count", 64'(bif.wb_count), 64'd0);
        check("t1_nlog", 64'(n_log), 64'(base + 1));
        check_log(base, 1'b0, 32'h100, 32'h0);
        tick();

        // 2: buffered writes, forwarded read of the newest duplicate
        mem_wait = 2;
        base = n_log;
        drive(1'b0, 1'b1, 32'h40, 32'h11);
        tick();
        drive(1'b0, 1'b1, 32'h44, 32'h22);
        tick();
        check("t2_ready_w2", 64'(bif.req_ready), 64'd1);
        drive(1'b0, 1'b1, 32'h40, 32'h33);
        tick();
        check("t2_wb_count", 64'(bif.wb_count), 64'd3);
        check("t2_ready_rd", 64'(bif.req_ready), 64'd1);
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("t2_fwd_valid", 64'(bif.rsp_valid), 64'd1);
        check("t2_fwd_data", 64'(bif.rsp_rdata), 64'h33);
        wait_log(base + 3);
        for (int i = 0; i < 6; i++) tick();
        check("t2_no_bus_read", 64'(n_log), 64'(base + 3));
        check("t2_drained", 64'(bif.wb_count), 64'd0);
        check_log(base + 0, 1'b1, 32'h40, 32'h11);
        check_log(base + 1, 1'b1, 32'h44, 32'h22);
        check_log(base + 2, 1'b1, 32'h40, 32'h33);

        // 3: full buffer with slow memory
        mem_wait = 2;
        base = n_log;
        for (int i = 0; i < 4; i++) begin
            check("t3_ready_fill", 64'(bif.req_ready), 64'd1);
            drive(1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        drive(1'b0, 1'b1, 32'h310, 32'hA4);
        check("t3_full_ready", 64'(bif.req_ready), 64'd0);
        check("t3_full_count", 64'(bif.wb_count), 64'd4);
        tick();
        check("t3_after_pop_ready", 64'(bif.req_ready), 64'd1);
        check("t3_after_pop_count", 64'(bif.wb_count), 64'd3);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("t3_fifth_in", 64'(bif.wb_count), 64'd4);
        wait_log(base + 5);
        for (int i = 0; i < 5; i++) check_log(base + i, 1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i));
        tick();
        tick();

        // 4: read miss overtakes the second buffered write
        mem_wait = 2;
        base = n_log;
        bif.bus_rdata = 32'hCAFEF00D;
        drive(1'b0, 1'b1, 32'h500, 32'h55);
        tick();
        drive(1'b0, 1'b1, 32'h504, 32'h66);
        tick();
        check("t4_in_wr_bus", 64'(bif.bus_req & bif.bus_we), 64'd1);
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 50 && !bif.rsp_valid; i++) tick();
        check("t4_rsp_valid", 64'(bif.rsp_valid), 64'd1);
        check("t4_rsp_rdata", 64'(bif.rsp_rdata), 64'hCAFEF00D);
        wait_log(base + 3);
        check_log(base + 0, 1'b1, 32'h500, 32'h55);
        check_log(base + 1, 1'b0, 32'h200, 32'h0);
        check_log(base + 2, 1'b1, 32'h504, 32'h66);
        tick();
        tick();

        // 5: illegal simultaneous read and write
        base = n_log;
        drive(1'b1, 1'b1, 32'h700, 32'h77);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("t5_err_pulse", 64'(bif.req_err), 64'd1);
        check("t5_count", 64'(bif.wb_count), 64'd0);
        check("t5_bus", 64'(bif.bus_req), 64'd0);
        tick();
        check("t5_err_clear", 64'(bif.req_err), 64'd0);
        check("t5_bus_idle", 64'(bif.bus_req), 64'd0);
        check("t5_no_rsp", 64'(bif.rsp_valid), 64'd0);
        tick();
        check("t5_nlog", 64'(n_log), 64'(base));

        // 6: reset during a bus read with two entries buffered, then a late ack
        mem_auto = 1'b0;
        drive(1'b0, 1'b1, 32'h900, 32'h90);
        tick();
        drive(1'b0, 1'b1, 32'h904, 32'h91);
        tick();
        drive(1'b0, 1'b1, 32'h908, 32'h92);
        tick();
        drive(1'b1, 1'b0, 32'h800, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        tick();
        check("t6_rd_bus", 64'(bif.bus_req), 64'd1);
        check("t6_rd_we", 64'(bif.bus_we), 64'd0);
        check("t6_rd_addr", 64'(bif.bus_addr), 64'h800);
        check("t6_buffered", 64'(bif.wb_count), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        manual_ack = 1'b1;
        check("t6_bus_req_rst", 64'(bif.bus_req), 64'd0);
        check("t6_count_rst", 64'(bif.wb_count), 64'd0);
        check("t6_rsp_rst", 64'(bif.rsp_valid), 64'd0);
        tick();
        manual_ack = 1'b0;
        check("t6_late_ack_rsp", 64'(bif.rsp_valid), 64'd0);
        check("t6_late_ack_bus", 64'(bif.bus_req), 64'd0);
        tick();
        check("t6_idle_rsp", 64'(bif.rsp_valid), 64'd0);
        check("t6_idle_bus", 64'(bif.bus_req), 64'd0);
        check("t6_idle_count", 64'(bif.wb_count), 64'd0);
        check("t6_ready", 64'(bif.req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
